// File: rtl/ring_occupancy_tracker.sv
// ============================================================================
// Module      : ring_occupancy_tracker
// Description : Head/tail/count tracker for a power-of-two ring buffer with
//               single pushes, burst pops, flush and a registered occupancy
//               mask. Define RING_OCC_ERR_EN to add sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ring_occupancy_tracker #(
    parameter int  LOG_DEPTH = 6,
    parameter int  MAX_POP   = 4,
    localparam int DEPTH     = 1 << LOG_DEPTH,
    localparam int POP_W     = $clog2(MAX_POP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic                 pop_valid,
    input  logic [POP_W-1:0]     pop_cnt,
    output logic                 pop_ready,
    output logic [LOG_DEPTH-1:0] head_idx,
    output logic [LOG_DEPTH-1:0] tail_idx,
    output logic [LOG_DEPTH:0]   count,
    output logic                 empty,
    output logic                 full,
    output logic [0:DEPTH-1]     valid_mask
`ifdef RING_OCC_ERR_EN
    ,
    output logic                 err_overflow,
    output logic                 err_underflow
`endif
);

    localparam int             CW        = LOG_DEPTH + 1;
    localparam logic [CW-1:0]  c_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0]  c_MAX_POP = CW'(MAX_POP);

    logic [LOG_DEPTH-1:0] r_head;
    logic [LOG_DEPTH-1:0] r_tail;
    logic [CW-1:0]        r_count;
    logic [0:DEPTH-1]     r_mask;

    logic [CW-1:0]        w_pop_ext;
    logic [CW-1:0]        w_pop_amt;
    logic                 w_push_ready;
    logic                 w_pop_ready;
    logic                 w_push_fire;
    logic                 w_pop_fire;
    logic [LOG_DEPTH-1:0] w_head_n;
    logic [LOG_DEPTH-1:0] w_tail_n;
    logic [CW-1:0]        w_count_n;
    logic [0:DEPTH-1]     w_mask_n;

    assign w_pop_ext    = CW'(pop_cnt);
    assign w_push_ready = (r_count != c_DEPTH);
    // Out-of-range pop counts are refused rather than truncated.
    assign w_pop_ready  = (w_pop_ext != '0) && (w_pop_ext <= c_MAX_POP) &&
                          (r_count >= w_pop_ext);
    assign w_push_fire  = push_valid && w_push_ready;
    assign w_pop_fire   = pop_valid && w_pop_ready;
    assign w_pop_amt    = w_pop_fire ? w_pop_ext : '0;

    always_comb begin
        w_head_n  = r_head;
        w_tail_n  = r_tail;
        w_count_n = r_count;
        if (flush) begin
            w_head_n  = r_tail;
            w_count_n = '0;
        end else begin
            w_tail_n  = r_tail + LOG_DEPTH'(w_push_fire);
            w_head_n  = r_head + w_pop_amt[LOG_DEPTH-1:0];
            w_count_n = r_count + CW'(w_push_fire) - w_pop_amt;
        end
    end

    // Entry i is live when its distance from head (mod DEPTH) is below count;
    // this covers the empty, full and wrapped cases uniformly.
    for (genvar i = 0; i < DEPTH; i++) begin : g_mask
        logic [LOG_DEPTH-1:0] w_off;
        assign w_off       = LOG_DEPTH'(i) - w_head_n;
        assign w_mask_n[i] = ({1'b0, w_off} < w_count_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mask  <= '0;
        end else begin
            r_head  <= w_head_n;
            r_tail  <= w_tail_n;
            r_count <= w_count_n;
            r_mask  <= w_mask_n;
        end
    end

`ifdef RING_OCC_ERR_EN
    logic r_err_ovf;
    logic r_err_udf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (push_valid && !w_push_ready)
                r_err_ovf <= 1'b1;
            if (pop_valid && !w_pop_ready && (w_pop_ext != '0))
                r_err_udf <= 1'b1;
        end
    end

    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_udf;
`endif

    assign push_ready = w_push_ready;
    assign pop_ready  = w_pop_ready;
    assign head_idx   = r_head;
    assign tail_idx   = r_tail;
    assign count      = r_count;
    assign empty      = (r_count == '0);
    assign full       = (r_count == c_DEPTH);
    assign valid_mask = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_ring_occupancy_tracker.sv
// ============================================================================
// Module      : tb_ring_occupancy_tracker
// Description : Directed plus randomized bench for ring_occupancy_tracker
//               against an entry-array reference model (DEPTH=8, MAX_POP=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ring_occupancy_tracker;

    localparam int LOG_DEPTH = 3;
    localparam int MAX_POP   = 4;
    localparam int DEPTH     = 1 << LOG_DEPTH;
    localparam int POP_W     = $clog2(MAX_POP + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 push_valid;
    logic                 push_ready;
    logic                 pop_valid;
    logic [POP_W-1:0]     pop_cnt;
    logic                 pop_ready;
    logic [LOG_DEPTH-1:0] head_idx;
    logic [LOG_DEPTH-1:0] tail_idx;
    logic [LOG_DEPTH:0]   count;
    logic                 empty;
    logic                 full;
    logic [0:DEPTH-1]     valid_mask;
`ifdef RING_OCC_ERR_EN
    logic                 err_overflow;
    logic                 err_underflow;
`endif

    ring_occupancy_tracker #(
        .LOG_DEPTH (LOG_DEPTH),
        .MAX_POP   (MAX_POP)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .pop_cnt    (pop_cnt),
        .pop_ready  (pop_ready),
        .head_idx   (head_idx),
        .tail_idx   (tail_idx),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .valid_mask (valid_mask)
`ifdef RING_OCC_ERR_EN
        ,
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: an explicit per-slot occupancy array.
    bit m_occ [DEPTH];
    int m_head, m_tail, m_count;
    bit m_ovf, m_udf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [0:DEPTH-1] model_mask();
        logic [0:DEPTH-1] m;
        for (int i = 0; i < DEPTH; i++) m[i] = m_occ[i];
        return m;
    endfunction

    function automatic bit model_pop_ok(input int pc);
        return (pc != 0) && (pc <= MAX_POP) && (m_count >= pc);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_occ[i] = 1'b0;
        m_head = 0; m_tail = 0; m_count = 0; m_ovf = 0; m_udf = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":head"},  32'(head_idx),   32'(m_head));
        chk({tag, ":tail"},  32'(tail_idx),   32'(m_tail));
        chk({tag, ":count"}, 32'(count),      32'(m_count));
        chk({tag, ":empty"}, 32'(empty),      32'(m_count == 0));
        chk({tag, ":full"},  32'(full),       32'(m_count == DEPTH));
        chk({tag, ":mask"},  32'(valid_mask), 32'(model_mask()));
        chk({tag, ":popcnt"}, 32'($countones(valid_mask)), 32'(m_count));
`ifdef RING_OCC_ERR_EN
        chk({tag, ":ovf"}, 32'(err_overflow),  32'(m_ovf));
        chk({tag, ":udf"}, 32'(err_underflow), 32'(m_udf));
`endif
    endtask

    // One clock: drive, check readies, clock, advance model, check state.
    task automatic step(input string tag, input bit pv, input bit ppv, input int pc,
                        input bit fl, input bit rs);
        bit push_ok, pop_ok;
        @(negedge clk);
        rst = rs; flush = fl; push_valid = pv; pop_valid = ppv;
        pop_cnt = POP_W'(pc);
        #1;
        push_ok = (m_count != DEPTH);
        pop_ok  = model_pop_ok(pc);
        chk({tag, ":push_ready"}, 32'(push_ready), 32'(push_ok));
        chk({tag, ":pop_ready"},  32'(pop_ready),  32'(pop_ok));
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
        end else begin
            if (pv && !push_ok) m_ovf = 1;
            if (ppv && !pop_ok && pc != 0) m_udf = 1;
            if (fl) begin
                for (int i = 0; i < DEPTH; i++) m_occ[i] = 1'b0;
                m_head = m_tail; m_count = 0;
            end else begin
                if (ppv && pop_ok) begin
                    for (int k = 0; k < pc; k++) begin
                        m_occ[m_head] = 1'b0;
                        m_head = (m_head + 1) % DEPTH;
                    end
                    m_count -= pc;
                end
                if (pv && push_ok) begin
                    m_occ[m_tail] = 1'b1;
                    m_tail = (m_tail + 1) % DEPTH;
                    m_count++;
                end
            end
        end
        check_state(tag);
    endtask

    task automatic pushes(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; push_valid = 0; pop_valid = 0; pop_cnt = '0;
        model_reset();

        step("reset", 0, 0, 0, 0, 1);
        chk("reset:mask_const", 32'(valid_mask), 32'h0);
        chk("reset:empty_const", 32'(empty), 32'h1);

        pushes("fill", 8);
        chk("fill:count_const", 32'(count), 32'd8);
        chk("fill:mask_const", 32'(valid_mask), 32'hFF);
        chk("fill:tail_const", 32'(tail_idx), 32'd0);
        chk("fill:push_ready_const", 32'(push_ready), 32'd0);
        step("overflow", 1, 0, 0, 0, 0);
        chk("overflow:count_const", 32'(count), 32'd8);

        step("rst2", 0, 0, 0, 0, 1);
        pushes("wrap_a", 6);
        step("wrap_pop", 0, 1, 4, 0, 0);
        pushes("wrap_b", 4);
        chk("wrap:head_const", 32'(head_idx), 32'd4);
        chk("wrap:tail_const", 32'(tail_idx), 32'd2);
        chk("wrap:count_const", 32'(count), 32'd6);
        chk("wrap:mask_const", 32'(valid_mask), 32'b11001111);

        step("rst3", 0, 0, 0, 0, 1);
        pushes("sim_fill", 6);
        step("sim_pop1", 0, 1, 1, 0, 0);
        step("sim_both", 1, 1, 3, 0, 0);
        chk("sim:head_const", 32'(head_idx), 32'd4);
        chk("sim:count_const", 32'(count), 32'd3);
        chk("sim:mask_const", 32'(valid_mask), 32'b00001110);

        step("udf_pop1", 0, 1, 1, 0, 0);
        step("udf_pop3", 0, 1, 3, 0, 0);
        chk("udf:count_const", 32'(count), 32'd2);
        step("udf_pop2", 0, 1, 2, 0, 0);
        chk("udf:empty_const", 32'(empty), 32'd1);
        chk("udf:head_eq_tail", 32'(head_idx), 32'd7);

        step("rst4", 0, 0, 0, 0, 1);
        pushes("fl_fill", 6);
        step("fl_pop1", 0, 1, 1, 0, 0);
        step("flush", 1, 1, 2, 1, 0);
        chk("flush:head_const", 32'(head_idx), 32'd6);
        chk("flush:count_const", 32'(count), 32'd0);

        step("rst5", 0, 0, 0, 0, 1);
        pushes("mid_a", 5);
        step("mid_pop4", 0, 1, 4, 0, 0);
        step("mid_pop1", 0, 1, 1, 0, 0);
        pushes("mid_b", 7);
        chk("mid:head_const", 32'(head_idx), 32'd5);
        chk("mid:count_const", 32'(count), 32'd7);
        step("mid_rst", 1, 1, 2, 0, 1);
        chk("mid:count_after_rst", 32'(count), 32'd0);

        for (int n = 0; n < 400; n++) begin
            step("rand",
                 bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 24) == 0),
                 bit'($urandom_range(0, 59) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
